// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//   Multi-cycle multiply/divide sequencer for the pipeline E stage. On issue
//   the operands are consumed and the full result is captured into pending
//   registers. A fixed-latency countdown then runs, and the result is committed
//   to HI/LO when the countdown ends. While an operation is in flight, busy is
//   high and md_stall holds any MD-class instruction waiting in D.
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous, active-low reset
//   start     in   1   E-stage MD op valid this cycle
//   mdu_op    in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 rsvd
//   rs_val    in   32  rs operand (dividend / multiplicand / MT data)
//   rt_val    in   32  rt operand (divisor / multiplier)
//   d_is_md   in   1   D-stage instruction is MD-class
//   busy      out  1   operation in flight (registered)
//   md_stall  out  1   D-stage MD hold request (combinational)
//   hi_out    out  32  HI register (registered)
//   lo_out    out  32  LO register (registered)
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (>=1)
//
// Build option
//   MDU_ZERO_DIV_FAST_EN  when defined, a divide by zero finishes after a
//                         single busy cycle instead of the full DIV_CYCLES.
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Count never exceeds MAX_CYCLES-1; keep at least one bit when MAX_CYCLES==1.
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   pend_hi_reg;
    logic [31:0]   pend_lo_reg;
    logic          pend_we_reg;   // cleared for divide by zero so commit leaves HI/LO alone

    // ---------------- issue-time arithmetic ----------------
    logic        is_mul;
    logic        is_div;
    logic        div_by_zero;
    logic        signed_div;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    assign is_mul      = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign is_div      = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign div_by_zero = (rt_val == 32'd0);
    assign signed_div  = (mdu_op == OP_DIV);

    // The low 64 bits of a product of sign-extended operands equal the
    // signed 64-bit product, so one unsigned multiplier serves both forms.
    assign mul_a   = (mdu_op == OP_MULT) ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
    assign mul_b   = (mdu_op == OP_MULT) ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
    assign product = mul_a * mul_b;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. |0x80000000| stays 0x80000000,
    // which as unsigned is 2^31, so 0x80000000 / -1 yields 0x80000000 rem 0.
    assign div_a  = (signed_div && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    assign div_b  = div_by_zero ? 32'd1 :
                    ((signed_div && rt_val[31]) ? (32'd0 - rt_val) : rt_val);
    assign quot   = div_a / div_b;
    assign rem    = div_a % div_b;
    assign div_lo = (signed_div && (rs_val[31] ^ rt_val[31])) ? (32'd0 - quot) : quot;
    assign div_hi = (signed_div && rs_val[31]) ? (32'd0 - rem) : rem;

    assign md_stall = d_is_md & (busy | (start & (is_mul | is_div)));

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            busy        <= 1'b0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            pend_we_reg <= 1'b0;
            hi_out      <= 32'd0;
            lo_out      <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            pend_hi_reg <= product[63:32];
                            pend_lo_reg <= product[31:0];
                            pend_we_reg <= 1'b1;
                            count_reg   <= MULT_LAST;
                            busy        <= 1'b1;
                            state_reg   <= RUN;
                        end else if (is_div) begin
                            pend_hi_reg <= div_hi;
                            pend_lo_reg <= div_lo;
                            pend_we_reg <= ~div_by_zero;
`ifdef MDU_ZERO_DIV_FAST_EN
                            count_reg   <= div_by_zero ? '0 : DIV_LAST;
`else
                            count_reg   <= DIV_LAST;
`endif
                            busy        <= 1'b1;
                            state_reg   <= RUN;
                        end else if (mdu_op == OP_MTHI) begin
                            hi_out <= rs_val;
                        end else if (mdu_op == OP_MTLO) begin
                            lo_out <= rs_val;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately ignored here; md_stall keeps it away.
                    if (count_reg == '0) begin
                        if (pend_we_reg) begin
                            hi_out <= pend_hi_reg;
                            lo_out <= pend_lo_reg;
                        end
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mdu_sequencer
//   Directed self-checking bench for mdu_sequencer with hand-computed vectors.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks;
    int n_errors;

    // Bench-side expectation of the architectural HI/LO contents.
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

`ifdef MDU_ZERO_DIV_FAST_EN
    localparam int DIV0_CYCLES = 1;
`else
    localparam int DIV0_CYCLES = 10;
`endif

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdu_op   (mdu_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .md_stall (md_stall),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one MULT/DIV-class op and follow it to completion.
    // spam keeps start high with a different op during RUN, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles,
                          input logic [31:0] res_hi, input logic [31:0] res_lo,
                          input logic dmd, input logic spam);
        int cyc;
        logic stall_ok;
        logic hold_ok;
        mdu_op  = op;
        rs_val  = a;
        rt_val  = b;
        d_is_md = dmd;
        start   = 1'b1;
        #1;
        check({tag, "_issue_stall"}, {31'd0, md_stall}, {31'd0, dmd});
        tick();
        if (spam) begin
            mdu_op = 3'd4;
            rs_val = 32'd100;
            rt_val = 32'd7;
            start  = 1'b1;
        end else begin
            mdu_op = 3'd0;
            start  = 1'b0;
        end
        #1;
        cyc      = 0;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            if (md_stall !== dmd) stall_ok = 1'b0;
            if (hi_out !== exp_hi || lo_out !== exp_lo) hold_ok = 1'b0;
            tick();
        end
        start  = 1'b0;
        mdu_op = 3'd0;
        #1;
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_run_stall"}, {31'd0, stall_ok}, 32'd1);
        check({tag, "_hilo_hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, "_stall_drop"}, {31'd0, md_stall}, 32'd0);
        check({tag, "_hi"}, hi_out, res_hi);
        check({tag, "_lo"}, lo_out, res_lo);
        exp_hi = res_hi;
        exp_lo = res_lo;
        $display("op %s rs=%h rt=%h busy=%0d hi=%h lo=%h", tag, a, b, cyc, hi_out, lo_out);
        d_is_md = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_hi   = 32'd0;
        exp_lo   = 32'd0;
        reset    = 1'b0;
        start    = 1'b0;
        mdu_op   = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        d_is_md  = 1'b0;

        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        #10 reset = 1'b1;
        tick();

        // Multiply, signed and unsigned, with D-stage MD instruction waiting.
        run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b0);
        run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1'b0);

        // Divide cases including sign handling and the overflow pair.
        run_op("div_m7_2",  3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0);
        run_op("divu_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
        run_op("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("div_7_m2",  3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);

        // MTHI then MTLO back to back; never busy, never stalls D.
        d_is_md = 1'b1;
        start   = 1'b1;
        mdu_op  = 3'd5;
        rs_val  = 32'h1234;
        #1;
        check("mthi_stall", {31'd0, md_stall}, 32'd0);
        tick();
        check("mthi_hi", hi_out, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        mdu_op = 3'd6;
        rs_val = 32'h5678;
        tick();
        check("mtlo_lo", lo_out, 32'h5678);
        check("mtlo_hi", hi_out, 32'h1234);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        $display("op mthi/mtlo hi=%h lo=%h busy=%0d", hi_out, lo_out, busy);
        // Reserved opcode with start: no effect.
        mdu_op = 3'd7;
        rs_val = 32'hDEAD;
        tick();
        check("rsvd_hi", hi_out, 32'h1234);
        check("rsvd_lo", lo_out, 32'h5678);
        check("rsvd_busy", {31'd0, busy}, 32'd0);

        // Preload HI=LO=0xAA, then divide by zero leaves them untouched.
        mdu_op = 3'd5;
        rs_val = 32'hAA;
        tick();
        mdu_op = 3'd6;
        tick();
        start   = 1'b0;
        mdu_op  = 3'd0;
        d_is_md = 1'b0;
        check("preload_hi", hi_out, 32'hAA);
        check("preload_lo", lo_out, 32'hAA);
        exp_hi = 32'hAA;
        exp_lo = 32'hAA;
        run_op("div_by0",  3'd3, 32'd55, 32'd0, DIV0_CYCLES, 32'hAA, 32'hAA, 1'b1, 1'b0);
        run_op("divu_by0", 3'd4, 32'd55, 32'd0, DIV0_CYCLES, 32'hAA, 32'hAA, 1'b0, 1'b0);

        // start held during RUN must be ignored; result is the first op's.
        run_op("mult_spam", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1, 1'b1);
        run_op("divu_17_5", 3'd4, 32'd17, 32'd5, 10, 32'd2, 32'd3, 1'b0, 1'b0);

        // Reset in the middle of a divide: immediate clear, no later commit.
        start  = 1'b1;
        mdu_op = 3'd4;
        rs_val = 32'd100;
        rt_val = 32'd7;
        tick();
        start  = 1'b0;
        mdu_op = 3'd0;
        tick();
        tick();
        tick();
        check("midrun_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        #3 reset = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("post_abort_busy", {31'd0, busy}, 32'd0);
        check("post_abort_hi", hi_out, 32'd0);
        check("post_abort_lo", lo_out, 32'd0);
        $display("op reset_abort busy=%0d hi=%h lo=%h", busy, hi_out, lo_out);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
